// File: rtl/rv32_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer: opcodes, FSM states, next-PC selects.
package rv32_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_TRAP   = 3'd6
   } state_e;

   localparam logic [6:0] OP_LUI      = 7'b0110111;
   localparam logic [6:0] OP_AUIPC    = 7'b0010111;
   localparam logic [6:0] OP_JAL      = 7'b1101111;
   localparam logic [6:0] OP_JALR     = 7'b1100111;
   localparam logic [6:0] OP_BRANCH   = 7'b1100011;
   localparam logic [6:0] OP_LOAD     = 7'b0000011;
   localparam logic [6:0] OP_STORE    = 7'b0100011;
   localparam logic [6:0] OP_OPIMM    = 7'b0010011;
   localparam logic [6:0] OP_OP       = 7'b0110011;
   localparam logic [6:0] OP_MISC_MEM = 7'b0001111;

   localparam logic [1:0] PC_PLUS4 = 2'b00;
   localparam logic [1:0] PC_BR    = 2'b01;
   localparam logic [1:0] PC_JALR  = 2'b10;

   // SYSTEM is deliberately absent: this core traps on it.
   function automatic logic is_legal(input logic [6:0] op);
      case (op)
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
         OP_LOAD, OP_STORE, OP_OPIMM, OP_OP, OP_MISC_MEM: is_legal = 1'b1;
         default:                                          is_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rv32_mem_wdog.sv
// Memory wait watchdog: counts stalled request cycles and flags when the limit is reached.
module rv32_mem_wdog #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic waiting,
   output logic timeout
);

   // One spare bit so the counter never wraps on its final increment.
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (waiting) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign timeout = waiting && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/rv32_multicycle_seq.sv
// RV32I multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB control strobes and retire counter.
// Optional memory watchdog enabled by defining RV_MEM_WDOG_EN.
module rv32_multicycle_seq
   import rv32_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned CNT_W          = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       opcode,
   input  logic             br_taken,
   output logic             imem_req,
   input  logic             imem_ready,
   output logic             ir_we,
   output logic             dmem_req,
   output logic             dmem_we,
   input  logic             dmem_ready,
   output logic             rf_we,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic             illegal,
   output logic             bus_err,
   output logic [CNT_W-1:0] instret,
   output logic [2:0]       state_dbg
);

   state_e state_q, state_d;
   logic   wdog_timeout;

`ifdef RV_MEM_WDOG_EN
   rv32_mem_wdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wdog (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (state_d != state_q),
      .waiting((imem_req && !imem_ready) || (dmem_req && !dmem_ready)),
      .timeout(wdog_timeout)
   );
`else
   assign wdog_timeout = 1'b0;
   assign bus_err      = 1'b0;
`endif

   // Strobes are decoded from the current state (plus ready for the Mealy ones),
   // so an asynchronous reset drops any pending request immediately.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
      state_d  = state_q;
      imem_req = 1'b0;
      ir_we    = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      rf_we    = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = PC_PLUS4;
      case (state_q)
         ST_IDLE: state_d = ST_FETCH;
         ST_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_we   = 1'b1;
               state_d = ST_DECODE;
            end else if (wdog_timeout) begin
               state_d = ST_TRAP;
            end
         end
         ST_DECODE: state_d = is_legal(opcode) ? ST_EXEC : ST_TRAP;
         ST_EXEC: begin
            case (opcode)
               OP_LOAD, OP_STORE: state_d = ST_MEM;
               OP_BRANCH: begin
                  pc_we   = 1'b1;
                  pc_sel  = br_taken ? PC_BR : PC_PLUS4;
                  state_d = ST_FETCH;
               end
               OP_MISC_MEM: begin
                  pc_we   = 1'b1;
                  state_d = ST_FETCH;
               end
               default: state_d = ST_WB;
            endcase
         end
         ST_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (opcode == OP_STORE);
            if (dmem_ready) begin
               if (opcode == OP_STORE) begin
                  pc_we   = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_WB;
               end
            end else if (wdog_timeout) begin
               state_d = ST_TRAP;
            end
         end
         ST_WB: begin
            rf_we   = 1'b1;
            pc_we   = 1'b1;
            pc_sel  = (opcode == OP_JAL)  ? PC_BR   :
                      (opcode == OP_JALR) ? PC_JALR : PC_PLUS4;
            state_d = ST_FETCH;
         end
         ST_TRAP: state_d = ST_TRAP;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         illegal <= 1'b0;
         instret <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state_q <= state_d;
         if (state_q == ST_DECODE && state_d == ST_TRAP) illegal <= 1'b1;
         if (pc_we) instret <= instret + 1'b1;
      end
   end

`ifdef RV_MEM_WDOG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_err <= 1'b0;
      end else if (wdog_timeout && (state_q == ST_FETCH || state_q == ST_MEM)) begin
         bus_err <= 1'b1;
      end
   end
`endif

   assign state_dbg = state_q;

endmodule

// File: doc/rv32_multicycle_seq.md
Name: rv32_multicycle_seq

Overview:
Multi-cycle instruction sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the enables around the combinational decoder and ALU: PC/IR/register-file write strobes, next-PC select, and the instruction/data memory request handshakes. It also counts retired instructions and traps on illegal opcodes.

Parameters:
TIMEOUT_CYCLES, 256, wait-cycle limit for the memory watchdog (used only with RV_MEM_WDOG_EN); minimum 2.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  core clock; all state changes on the rising edge.
rst_n  in  1  asynchronous active-low reset.
opcode  in  7  instr[6:0] from IR; stable from DECODE through WB.
br_taken  in  1  branch comparator result, sampled in EXEC.
imem_req  out  1  instruction fetch request.
imem_ready  in  1  instruction word valid / fetch accepted.
ir_we  out  1  IR load strobe.
dmem_req  out  1  data memory request.
dmem_we  out  1  1 = store, 0 = load; valid while dmem_req = 1.
dmem_ready  in  1  data access complete.
rf_we  out  1  register-file write strobe.
pc_we  out  1  PC update strobe.
pc_sel  out  2  next PC: 00 = PC+4, 01 = PC+imm (branch/JAL), 10 = rs1+imm (JALR), 11 unused.
illegal  out  1  sticky illegal-opcode trap flag.
bus_err  out  1  sticky memory-timeout flag (always 0 without RV_MEM_WDOG_EN).
instret  out  CNT_W  retired-instruction count.
state_dbg  out  3  current state encoding.

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- Reset (async): state = IDLE, instret = 0, illegal = 0, bus_err = 0. All strobes are Moore/Mealy decodes of state and are 0 in IDLE.
- IDLE: all strobes 0. Next state is FETCH unconditionally (one cycle after reset release).
- FETCH: imem_req = 1 and held until imem_ready. On the imem_ready cycle: ir_we = 1, then go to DECODE. imem_ready outside FETCH is ignored.
- DECODE: one cycle. Legal opcodes go to EXEC; any other value goes to TRAP.
  - Legal: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, MISC-MEM 0001111.
  - SYSTEM (1110011) is treated as illegal.
- EXEC: one cycle.
  - LOAD or STORE: go to MEM.
  - BRANCH: pc_we = 1, pc_sel = br_taken ? 01 : 00, go to FETCH (retire).
  - MISC-MEM: pc_we = 1, pc_sel = 00, go to FETCH (retire, no-op).
  - All others: go to WB.
- MEM: dmem_req = 1, dmem_we = (opcode == STORE), both held stable until dmem_ready.
  - On dmem_ready with STORE: pc_we = 1, pc_sel = 00, go to FETCH (retire).
  - On dmem_ready with LOAD: go to WB.
- WB: rf_we = 1, pc_we = 1. pc_sel = 01 for JAL, 10 for JALR, 00 otherwise. Go to FETCH (retire).
- TRAP: illegal = 1 (sticky). No requests or strobes are issued; TRAP is left only by reset.
- Retire: instret increments by 1 in every cycle where pc_we = 1. It wraps from all-ones to 0.
- Latency with zero-wait memory (FETCH through retire):
  - BRANCH / MISC-MEM: 3 cycles.
  - STORE, ALU ops, LUI/AUIPC, JAL/JALR: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle adds one cycle.
- Reset asserted mid-FETCH or mid-MEM: the request drops immediately (asynchronous). No strobe fires for the aborted instruction.
- At most one of ir_we, rf_we and dmem_req-accepted fires per cycle; pc_we never fires in FETCH or DECODE.

Optional Feature:
RV_MEM_WDOG_EN:
- Defined: a wait counter clears on entry to FETCH or MEM and increments each cycle that imem_req or dmem_req is high without ready. When it reaches TIMEOUT_CYCLES-1 with ready still low, the next state is TRAP and bus_err = 1 (sticky); illegal stays 0.
- Undefined: no counter; bus_err is tied to 0; waits are unbounded.

Decomposition:
- Package rv32_pkg: opcode constants, state encoding constants, pc_sel encodings (PC_PLUS4, PC_BR, PC_JALR).
- Sub-module rv32_mem_wdog: the watchdog counter (clk, rst_n, clear, waiting, timeout). Instantiated only under RV_MEM_WDOG_EN.

Test Plan:
- Reset, then ADD (opcode 0110011) with imem_ready tied 1. Required: ir_we in the first FETCH cycle; rf_we = 1, pc_we = 1 and pc_sel = 00 four cycles after FETCH entry; instret = 1.
- LW with dmem_ready delayed 3 cycles. Required: dmem_req = 1 and dmem_we = 0 held 4 cycles; WB follows with rf_we = 1; instret += 1.
- SW with zero-wait memory. Required: dmem_we = 1 in MEM; pc_we = 1 on dmem_ready; rf_we never asserts; back in FETCH next cycle.
- BEQ with br_taken = 1, then BEQ with br_taken = 0. Required: pc_we in EXEC with pc_sel = 01, then 00; no rf_we; 3-cycle retire each.
- JALR (1100111). Required: WB with rf_we = 1 and pc_sel = 10. Then opcode 1111111: TRAP, illegal = 1, imem_req stays 0 for 20 cycles; rst_n low clears it.
- With RV_MEM_WDOG_EN and TIMEOUT_CYCLES = 16, hold imem_ready = 0. Required: bus_err = 1 and state_dbg = 6 after 16 FETCH cycles; instret unchanged.
